inv_round_engine: RTL and testbench
===================================

Name: inv_round_engine

Overview:
- Iterative AES-128 decryption datapath; the inverse counterpart of the encryption round logic.
- Accepts one 128-bit ciphertext block over a valid/ready handshake.
- Runs the initial AddRoundKey, then 9 full inverse rounds, then the final inverse round (InvShiftRows, InvSubBytes, AddRoundKey with round key 0), one round per clock.
- Fetches round keys by index from the existing external key-schedule store, and returns plaintext over a valid/ready handshake.

Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is supported; any other value is a configuration error.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state
- in_valid  in  1  ciphertext block present on in_data
- in_ready  out  1  engine can accept a block
- in_data  in  128  ciphertext; byte0 = bits[127:120], column-major (FIPS-197 order, same as the subbytes/shiftrows modules)
- key_round  out  4  index of the round key needed this cycle (0..10)
- key_in  in  128  round key for key_round; the key store returns it combinationally in the same cycle
- out_valid  out  1  plaintext valid on out_data
- out_ready  in  1  consumer accepts the plaintext
- out_data  out  128  plaintext, registered
- busy  out  1  high in RUN, LAST and DONE

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, round counter=0, internal state register=0.
  - out_data=0, out_valid=0, in_ready=1 once rst releases.
  - busy=0, key_round=10.
  - Reset mid-block discards the block silently.
- FSM states: IDLE, RUN, LAST, DONE.
- IDLE:
  - in_ready=1, key_round=10.
  - On in_valid&in_ready: st <= in_data ^ key_in; rnd <= 9; go to RUN.
- RUN:
  - in_ready=0, key_round=rnd.
  - Each cycle: st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ key_in); rnd <= rnd-1.
  - When rnd==1, go to LAST.
- LAST:
  - key_round=0.
  - out_data <= InvSubBytes(InvShiftRows(st)) ^ key_in; out_valid <= 1; go to DONE.
- DONE:
  - out_valid=1, out_data held stable, key_round=0.
  - On out_ready: out_valid <= 0; go to IDLE.
  - out_ready low holds DONE indefinitely (backpressure), with no data change.
- Latency: out_valid rises 10 clocks after the accepting edge. Without the optional feature, the minimum block period is 12 clocks.
- in_data and in_valid are ignored whenever in_ready=0. in_valid may be held high across a busy period; the next block is taken on the first cycle in_ready=1.
- key_in is sampled only in IDLE (on accept), RUN and LAST. Its value in DONE is don't-care.
- InvShiftRows: row r rotated right by r bytes.
- InvSubBytes: uses the combinational inv_subbytes helper module (inverse S-box).
- InvMixColumns: implemented in this block with GF(2^8) xtime chains, multipliers {0e,0b,0d,09}, reduction polynomial 0x11b.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Optional Feature:
- Macro: INV_ROUND_B2B_EN.
- When defined:
  - in_ready is also 1 in DONE while out_ready=1.
  - A simultaneous output handshake and input accept goes DONE -> RUN directly (st <= in_data ^ key_in, key_round=10 in that cycle, out_valid <= 0).
  - Block period becomes 11 clocks.
  - key_round in DONE = 10.
- When undefined: behaviour exactly as above; DONE always returns to IDLE.

Test Plan:
- FIPS-197 C.1:
  - key 000102030405060708090a0b0c0d0e0f (bench key model supplies the round keys; rk10 = 13111d7fe3944a17f307a78b4d2b30c5).
  - ct 69c4e0d86a7b0430d8cdb78070b4c55a -> out_data 00112233445566778899aabbccddeeff.
  - out_valid exactly 10 clocks after accept.
- FIPS-197 App. B:
  - key 2b7e151628aed2a6abf7158809cf4f3c.
  - ct 3925841d02dc09fbdc118597196a0b32 -> pt 3243f6a8885a308d313198a2e0370734.
  - key_round sequence 10,9,...,1,0.
- Backpressure:
  - hold out_ready=0 for 20 clocks after out_valid -> out_data stable, in_ready=0, busy=1.
  - raise out_ready -> one handshake, then in_ready=1 next cycle.
- Reset mid-operation:
  - assert rst low asynchronously at RUN rnd=5 -> out_valid=0, out_data=0 immediately.
  - after release, C.1 vector decrypts correctly.
- Back-to-back:
  - in_valid held high with both vectors queued, out_ready=1 -> two correct outputs.
  - accept edges 12 clocks apart (11 with INV_ROUND_B2B_EN).
- Ignored input: toggle in_data and in_valid during RUN -> result unchanged and no extra output.

Source files
------------

// File: rtl/inv_round_engine.sv
// inv_round_engine: iterative AES-128 decryption datapath, one inverse round per clock.
// Takes a ciphertext block over valid/ready, fetches round keys by index from an
// external key-schedule store, and returns the plaintext over valid/ready.
// Optional feature macro: INV_ROUND_B2B_EN. It lets a new block be accepted in the
// same cycle the previous plaintext is handed off, giving an 11-clock block period
// instead of 12.

// Combinational inverse S-box applied to all 16 bytes of a block.
module inv_subbytes (
    input  logic [127:0] din,
    output logic [127:0] dout
);

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign dout[127-8*i -: 8] = INV_SBOX[din[127-8*i -: 8]];
    end

endmodule

// Iterative inverse-cipher engine with a four-state control FSM.
module inv_round_engine #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   key_round,
    input  logic [127:0] key_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    // The round counter and key index are sized for AES-128 only.
    if (NR != 10) begin : g_nr_check
        $error("inv_round_engine: only NR=10 (AES-128) is supported");
    end

    localparam logic [3:0] LAST_KEY  = 4'(NR);
    localparam logic [3:0] FIRST_RND = 4'(NR - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LAST,
        DONE
    } state_t;

    state_t       state;
    state_t       next_state;
    logic [127:0] st;
    logic [3:0]   rnd;
    logic         load_in;
    logic         do_round;
    logic         do_final;
    logic         out_clear;
    logic [127:0] isr;
    logic [127:0] isb;
    logic [127:0] ark;
    logic [127:0] imc;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiplies one column by the inverse MixColumns matrix {0e,0b,0d,09}.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            r[127-32*c -: 32] = inv_mix_column(s[127-32*c -: 32]);
        end
        return r;
    endfunction

    // Row w moves right by w byte positions, so output column c takes input column c-w.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(w+4*c) -: 8] = s[127-8*(w+4*((c-w+4)%4)) -: 8];
            end
        end
        return r;
    endfunction

    // Shared round datapath: the LAST state uses ark directly, RUN adds InvMixColumns.
    always_comb begin
        isr = inv_shift_rows(st);
        ark = isb ^ key_in;
        imc = inv_mix_columns(ark);
    end

    inv_subbytes u_inv_subbytes (
        .din  (isr),
        .dout (isb)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus handshake, key-index and datapath enables.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        key_round  = 4'd0;
        busy       = 1'b1;
        load_in    = 1'b0;
        do_round   = 1'b0;
        do_final   = 1'b0;
        out_clear  = 1'b0;
        case (state)
            IDLE: begin
                in_ready  = 1'b1;
                key_round = LAST_KEY;
                busy      = 1'b0;
                if (in_valid) begin
                    load_in    = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                key_round = rnd;
                do_round  = 1'b1;
                if (rnd == 4'd1) begin
                    next_state = LAST;
                end
            end
            LAST: begin
                do_final   = 1'b1;
                next_state = DONE;
            end
            DONE: begin
`ifdef INV_ROUND_B2B_EN
                key_round = LAST_KEY;
                in_ready  = out_ready;
                if (out_ready) begin
                    out_clear = 1'b1;
                    if (in_valid) begin
                        load_in    = 1'b1;
                        next_state = RUN;
                    end else begin
                        next_state = IDLE;
                    end
                end
`else
                if (out_ready) begin
                    out_clear  = 1'b1;
                    next_state = IDLE;
                end
`endif
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register and round counter: initial AddRoundKey on accept, then full inverse rounds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st  <= '0;
            rnd <= 4'd0;
        end else if (load_in) begin
            st  <= in_data ^ key_in;
            rnd <= FIRST_RND;
        end else if (do_round) begin
            st  <= imc;
            rnd <= rnd - 4'd1;
        end
    end

    // Output register: captured by the final round, held until the consumer takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (do_final) begin
            out_data  <= ark;
            out_valid <= 1'b1;
        end else if (out_clear) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inv_round_engine.sv
// tb_inv_round_engine: directed FIPS-197 vectors against a bench-side AES model.
// The S-box is derived from GF(2^8) inversion plus the affine map, round keys come
// from a bench key expansion, and a cycle-count model predicts the handshakes.
// Honours INV_ROUND_B2B_EN the same way the design does.
module tb_inv_round_engine;

    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_KEY   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT    = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef INV_ROUND_B2B_EN
    localparam int PERIOD = 11;
    localparam bit B2B    = 1'b1;
`else
    localparam int PERIOD = 12;
    localparam bit B2B    = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   key_round;
    logic [127:0] key_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic [7:0]   sbox  [256];
    logic [7:0]   isbox [256];
    logic [127:0] rks   [11];
    logic [3:0]   kr_seq [16];
    logic [127:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_count = 0;
    int acc_last = 0;
    int acc_prev = 0;
    bit m_idle = 1'b1;
    int m_phase = 0;

    inv_round_engine #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .key_round (key_round),
        .key_in    (key_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External key store: combinational lookup by the requested round index.
    assign key_in = (key_round <= 4'd10) ? rks[key_round] : 128'h0;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // Forward S-box from multiplicative inverse and affine transform; inverse table by lookup.
    task automatic build_sbox;
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x] = s;
        end
        for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
    endtask

    // AES-128 key expansion into the round-key store.
    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Textbook inverse cipher on a 16-byte array using the current round keys.
    function automatic logic [127:0] model_decrypt(input logic [127:0] ct);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [127:0] pt;
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ rks[10][127-8*i -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    t[w+4*c] = s[w+4*((c-w+4)%4)];
            for (int i = 0; i < 16; i++) s[i] = isbox[t[i]] ^ rks[r][127-8*i -: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int i = 0; i < 4; i++) a[i] = s[4*c+i];
                    s[4*c+0] = gmul(a[0], 8'h0e) ^ gmul(a[1], 8'h0b) ^ gmul(a[2], 8'h0d) ^ gmul(a[3], 8'h09);
                    s[4*c+1] = gmul(a[0], 8'h09) ^ gmul(a[1], 8'h0e) ^ gmul(a[2], 8'h0b) ^ gmul(a[3], 8'h0d);
                    s[4*c+2] = gmul(a[0], 8'h0d) ^ gmul(a[1], 8'h09) ^ gmul(a[2], 8'h0e) ^ gmul(a[3], 8'h0b);
                    s[4*c+3] = gmul(a[0], 8'h0b) ^ gmul(a[1], 8'h0d) ^ gmul(a[2], 8'h09) ^ gmul(a[3], 8'h0e);
                end
            end
        end
        pt = '0;
        for (int i = 0; i < 16; i++) pt[127-8*i -: 8] = s[i];
        return pt;
    endfunction

    // Reference model: phase counts clocks since the accepting edge; a queue holds expected plaintext.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_idle  <= 1'b1;
            m_phase <= 0;
            exp_q.delete();
        end else if (m_idle) begin
            if (in_valid) begin
                exp_q.push_back(model_decrypt(in_data));
                m_idle  <= 1'b0;
                m_phase <= 0;
            end
        end else if (m_phase >= 10) begin
            if (out_ready) begin
                void'(exp_q.pop_front());
                if (B2B && in_valid) begin
                    exp_q.push_back(model_decrypt(in_data));
                    m_phase <= 0;
                end else begin
                    m_idle <= 1'b1;
                end
            end
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    // Accept-edge monitor used for block-period measurement.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && in_valid && in_ready) begin
            acc_prev  <= acc_last;
            acc_last  <= cyc;
            acc_count <= acc_count + 1;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic       e_done;
        logic [3:0] e_kr;
        #1;
        if (rst) begin
            e_done = !m_idle && (m_phase >= 10);
            if (m_idle)            e_kr = 4'd10;
            else if (m_phase <= 8) e_kr = 4'(9 - m_phase);
            else if (e_done && B2B) e_kr = 4'd10;
            else                   e_kr = 4'd0;
            check_output("cyc in_ready", in_ready, m_idle || (B2B && e_done && out_ready));
            check_output("cyc busy", busy, !m_idle);
            check_output("cyc out_valid", out_valid, e_done);
            check_output("cyc key_round", key_round, e_kr);
            if (e_done && exp_q.size() > 0) check_output("cyc out_data", out_data, exp_q[0]);
        end
    end

    task automatic apply_stimulus(input logic [127:0] ct, input logic [127:0] key);
        int t;
        t = 0;
        @(negedge clk);
        load_key(key);
        in_data  = ct;
        in_valid = 1'b1;
        #1;
        while (!in_ready && t < 40) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_output("accept wait", t < 40, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Called just after the accepting edge; measures latency and records key indices.
    task automatic wait_output(input logic [127:0] exp_pt, input string tag);
        int lat;
        lat = 0;
        kr_seq[0] = key_round;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat < 16) kr_seq[lat] = key_round;
        end
        check_output({tag, " latency"}, lat, 10);
        check_output({tag, " data"}, out_data, exp_pt);
    endtask

    task automatic drain;
        @(posedge clk);
        #1;
    endtask

    task automatic run_b2b;
        int           n_out;
        int           t;
        int           start_acc;
        logic [127:0] got [2];
        n_out     = 0;
        t         = 0;
        got[0]    = '0;
        got[1]    = '0;
        start_acc = acc_count;
        @(negedge clk);
        load_key(C1_KEY);
        in_data  = C1_CT;
        in_valid = 1'b1;
        while (n_out < 2 && t < 80) begin
            @(negedge clk);
            t++;
            if (acc_count - start_acc >= 2) in_valid = 1'b0;
            if (out_valid) begin
                got[n_out] = out_data;
                n_out++;
                if (n_out == 1) begin
                    load_key(B_KEY);
                    in_data = B_CT;
                end
            end
        end
        in_valid = 1'b0;
        check_output("b2b outputs", n_out, 2);
        check_output("b2b first", got[0], C1_PT);
        check_output("b2b second", got[1], B_PT);
        check_output("b2b period", acc_last - acc_prev, PERIOD);
        drain();
    endtask

    initial begin
        int t;
        int extra;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;

        build_sbox();
        load_key(C1_KEY);
        check_output("model rk10", rks[10], C1_RK10);
        check_output("model c1", model_decrypt(C1_CT), C1_PT);
        load_key(B_KEY);
        check_output("model appb", model_decrypt(B_CT), B_PT);

        repeat (3) @(negedge clk);
        #1;
        check_output("reset out_valid", out_valid, 1'b0);
        check_output("reset out_data", out_data, 128'h0);
        check_output("reset busy", busy, 1'b0);
        check_output("reset key_round", key_round, 4'd10);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("reset in_ready", in_ready, 1'b1);

        $display("[TB] FIPS-197 C.1");
        apply_stimulus(C1_CT, C1_KEY);
        wait_output(C1_PT, "c1");
        drain();

        $display("[TB] FIPS-197 App. B");
        apply_stimulus(B_CT, B_KEY);
        wait_output(B_PT, "appb");
        for (int i = 0; i < 10; i++) check_output("appb key_round", kr_seq[i], (i <= 8) ? 4'(9 - i) : 4'd0);
        drain();

        $display("[TB] backpressure");
        @(negedge clk);
        out_ready = 1'b0;
        apply_stimulus(C1_CT, C1_KEY);
        wait_output(C1_PT, "bp");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check_output("bp hold data", out_data, C1_PT);
            check_output("bp hold in_ready", in_ready, 1'b0);
            check_output("bp hold busy", busy, 1'b1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        drain();
        check_output("bp release out_valid", out_valid, 1'b0);
        check_output("bp release in_ready", in_ready, 1'b1);

        $display("[TB] reset mid-operation");
        apply_stimulus(C1_CT, C1_KEY);
        t = 0;
        while (key_round != 4'd5 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_output("rst reach rnd5", t < 20, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_output("rst out_valid", out_valid, 1'b0);
        check_output("rst out_data", out_data, 128'h0);
        check_output("rst busy", busy, 1'b0);
        check_output("rst key_round", key_round, 4'd10);
        @(negedge clk);
        rst = 1'b1;
        apply_stimulus(C1_CT, C1_KEY);
        wait_output(C1_PT, "rst c1");
        drain();

        $display("[TB] back-to-back");
        run_b2b();

        $display("[TB] ignored input");
        @(negedge clk);
        apply_stimulus(B_CT, B_KEY);
        fork
            begin
                for (int i = 0; i < 7; i++) begin
                    @(negedge clk);
                    in_valid = 1'($urandom_range(0, 1));
                    in_data  = {$urandom, $urandom, $urandom, $urandom};
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            wait_output(B_PT, "ign");
        join
        drain();
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) extra++;
        end
        check_output("ign extra outputs", extra, 0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

endmodule
